rle_decoder: RTL

- Run-length decompressor: consumes (value, count) tokens from the compressed stream and expands each into count+1 repeated output words.
- Sits on the decompression path as the inverse of the team's run-length encoder.
- Valid/ready on both sides; one registered output stage; accepts the next token in the same cycle the last word of the current run is taken, giving zero bubbles between runs.

---
 rtl/rle_pkg.sv | 18 +
 rtl/rle_run_counter.sv | 28 ++
 rtl/rle_decoder.sv | 79 +++++++
 3 files changed

// File: rtl/rle_pkg.sv
// Shared types and default widths for the run-length decoder.
package rle_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 32;
    localparam int DEFAULT_COUNT_WIDTH = 8;

    typedef struct packed {
        logic [DEFAULT_DATA_WIDTH-1:0]  data;
        logic [DEFAULT_COUNT_WIDTH-1:0] count;
        logic                           last;
    } token_t;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/rle_run_counter.sv
// Loadable down-counter with a zero flag; holds the words still to emit
// after the one currently presented.
module rle_run_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             is_zero
);

    // Load takes priority over decrement; the zero guard keeps the count from wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign is_zero = (count == '0);

endmodule

// File: rtl/rle_decoder.sv
// Run-length decompressor: expands (value, count) tokens into count+1 words.
// Define RLE_DECODER_STATS_EN to add token/word handshake counters.
module rle_decoder
    import rle_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [COUNT_WIDTH-1:0] in_count,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_last
`ifdef RLE_DECODER_STATS_EN
    ,
    output logic [31:0]            stat_tokens,
    output logic [31:0]            stat_words
`endif
);

    state_t                 state;
    logic                   last_tok;
    logic [COUNT_WIDTH-1:0] remaining;
    logic                   rem_zero;
    logic                   accept;
    logic                   take;

    assign out_valid = (state == EMIT);
    assign take      = out_valid && out_ready;
    // A new token may enter while the final word of the current run leaves.
    assign in_ready  = !out_valid || (out_ready && rem_zero);
    assign accept    = in_valid && in_ready;
    assign out_last  = out_valid && last_tok && rem_zero;

    rle_run_counter #(
        .WIDTH(COUNT_WIDTH)
    ) u_remaining (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (in_count),
        .dec      (take && !accept),
        .count    (remaining),
        .is_zero  (rem_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            out_data <= '0;
            last_tok <= 1'b0;
        end else if (accept) begin
            state    <= EMIT;
            out_data <= in_data;
            last_tok <= in_last;
        end else if (take && rem_zero) begin
            state    <= IDLE;
        end
    end

`ifdef RLE_DECODER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_tokens <= '0;
            stat_words  <= '0;
        end else begin
            if (accept) stat_tokens <= stat_tokens + 32'd1;
            if (take)   stat_words  <= stat_words + 32'd1;
        end
    end
`endif

endmodule
